ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM: one operation
// in flight, IDLE -> ACCESS -> RESP. Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                gnt0_c, gnt1_c;
  logic                pick1;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                rr_q, rr_d;
`endif

  // pick1 selects requester 1; on a tie the one not served last wins.
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  assign pick1 = req1 & (~req0 | ~rr_q);
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt0_c  = ~pick1;
          gnt1_c  = pick1;
          owner_d = pick1;
          we_d    = pick1 ? we1    : we0;
          addr_d  = pick1 ? addr1  : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          rr_d    = pick1;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        done0_d = ~owner_q;
        done1_d = owner_q;
        state_d = RESP;
      end
      RESP: begin
        if (!we_q) rdata_d = ram_data_out;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Grants are combinational so they must be masked while reset is held.
  assign gnt0             = gnt0_c & rst_n;
  assign gnt1             = gnt1_c & rst_n;
  assign done0            = done0_q;
  assign done1            = done1_q;
  assign ram_address      = addr_q;
  assign ram_data_in      = wdata_q;
  assign ram_write_enable = (state_q == ACCESS) & we_q;
  // Read data is forwarded from the RAM during RESP so it lines up with done.
  assign rdata            = (state_q == RESP && !we_q) ? ram_data_out : rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk, rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_address;
  logic          ram_write_enable;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .ram_data_in(ram_data_in), .ram_address(ram_address),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  typedef struct {
    int            id;
    bit            rd;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] ram_mem   [64];
  logic [DW-1:0] model_mem [64];
  exp_t          sb [$];
  int            gid_log [$];
  int            gcyc_log [$];
  int            cyc = 0;
  int            last_gnt = -100;
  logic [DW-1:0] last_rd = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Read-first synchronous RAM: data appears one edge after the address is sampled.
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_address];
  end

  initial begin : monitor
    exp_t          e;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
        check_eq("done_excl", {31'd0, done0 & done1}, 0);
        if (done0 | done1) begin
          if (sb.size() == 0) check_eq("unexp_done", 1, 0);
          else begin
            e = sb.pop_front();
            check_eq("done_id", {31'd0, done1}, e.id);
            check_eq("done_cyc", cyc, e.due);
            if (e.rd) begin
              check_eq("rdata", {24'd0, rdata}, {24'd0, e.data});
              last_rd = rdata;
            end else check_eq("rdata_hold", {24'd0, rdata}, {24'd0, last_rd});
          end
        end
        if (gnt0 | gnt1) begin
          if (gnt1) begin wr = we1; a = addr1; d = wdata1; end
          else      begin wr = we0; a = addr0; d = wdata0; end
          e.id  = gnt1 ? 1 : 0;
          e.rd  = !wr;
          e.due = cyc + 2;
          if (wr) model_mem[a] = d;
          e.data = model_mem[a];
          check_eq("gnt_gap", {31'd0, (cyc - last_gnt) >= 3}, 1);
          last_gnt = cyc;
          gid_log.push_back(e.id);
          gcyc_log.push_back(cyc);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    check_eq("rst_outs", {5'd0, gnt0, gnt1, done0, done1, ram_write_enable,
                          ram_address, ram_data_in, rdata}, 0);
    sb.delete();
    last_rd  = '0;
    last_gnt = -100;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_op(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    if (id == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else         begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((id == 0 && gnt0) || (id == 1 && gnt1)) begin got = 1; break; end
    end
    if (!got) check_eq("gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin empty = 1; break; end
    end
    if (!empty) check_eq("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int exp_seq [4];
    bit ok;
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 64; i++) begin ram_mem[i] = '0; model_mem[i] = '0; end
    rst_n = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(posedge clk);
    #1;
    apply_reset();

    // Write then read back on requester 0.
    do_op(0, 1'b1, 6'd5, 8'hA5);
    do_op(0, 1'b0, 6'd5, 8'h00);
    drain();

    // Both requesters held high continuously.
    apply_reset();
    gid_log.delete(); gcyc_log.delete();
    we0 = 0; addr0 = 6'd1; we1 = 0; addr1 = 6'd2;
    req0 = 1; req1 = 1;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (gid_log.size() >= 4) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    req0 = 0; req1 = 0;
    if (!ok) check_eq("rr_timeout", 0, 1);
    else begin
      for (int i = 0; i < 4; i++) check_eq("rr_order", gid_log[i], exp_seq[i]);
      for (int i = 1; i < 4; i++) check_eq("rr_spacing", gcyc_log[i] - gcyc_log[i-1], 3);
    end
    drain();

    // Simultaneous write(1) / read(0) of address 63 after reset.
    do_op(1, 1'b1, 6'd63, 8'h11);
    drain();
    apply_reset();
    gid_log.delete(); gcyc_log.delete();
    fork
      do_op(1, 1'b1, 6'd63, 8'hFF);
      do_op(0, 1'b0, 6'd63, 8'h00);
    join
    drain();
    check_eq("tie_first", gid_log.size() > 0 ? gid_log[0] : 9, 0);
    do_op(0, 1'b0, 6'd63, 8'h00);
    drain();

    // Reset during ACCESS of a read abandons it.
    do_op(1, 1'b0, 6'd7, 8'h00);
    apply_reset();
    repeat (4) @(posedge clk);
    #1;
    gid_log.delete(); gcyc_log.delete();
    fork
      do_op(0, 1'b0, 6'd1, 8'h00);
      do_op(1, 1'b0, 6'd2, 8'h00);
    join
    drain();
    check_eq("post_rst_tie", gid_log.size() > 0 ? gid_log[0] : 9, 0);

    // Write addr 0, idle, then read it back.
    do_op(0, 1'b1, 6'd0, 8'h3C);
    drain();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("idle_we", {31'd0, ram_write_enable}, 0);
      check_eq("idle_addr", {26'd0, ram_address}, 0);
    end
    @(posedge clk);
    #1;
    do_op(0, 1'b0, 6'd0, 8'h00);
    drain();
    check_eq("final_rdata", {24'd0, rdata}, 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
